// File: rtl/rgb_fader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fader_pkg
// Brief    : FSM encoding and {R,G,B} channel-slice constants for the fader
//            and the downstream PWM stage.
// Revision : 1.0
// ============================================================================
package rgb_fader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Channel N occupies colour bits [N*NBPC +: NBPC]; R sits in the MSBs.
    localparam int NUM_CH = 3;
    localparam int CH_R   = 2;
    localparam int CH_G   = 1;
    localparam int CH_B   = 0;

    function automatic int ch_lsb(input int ch, input int nbpc);
        return ch * nbpc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_fader_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fader_if
// Brief    : Control, colour-table write and status bundle of the fader.
// Revision : 1.0
// ============================================================================
interface rgb_fader_if #(
    parameter int NBPC = 8,
    parameter int NCOL = 4
);
    localparam int IW = $clog2(NCOL);

    logic                en;
    logic                wr_en;
    logic [IW-1:0]       wr_idx;
    logic [3*NBPC-1:0]   wr_data;
    logic [7:0]          hold;
    logic                loop;
    logic                start;
    logic                stop;
    logic [3*NBPC-1:0]   color;
    logic                busy;
    logic [IW-1:0]       idx;
    logic                step_done;

    modport master (
        output en, wr_en, wr_idx, wr_data, hold, loop, start, stop,
        input  color, busy, idx, step_done
    );

    modport slave (
        input  en, wr_en, wr_idx, wr_data, hold, loop, start, stop,
        output color, busy, idx, step_done
    );

endinterface
`default_nettype wire

// File: rtl/rgb_fader_counter.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fader_counter
// Brief    : Wrapping MIN..MAX counter; ovf strobes on the wrapping cycle.
// Revision : 1.0
// ============================================================================
module rgb_fader_counter #(
    parameter int MIN  = 0,
    parameter int MAX  = 999,
    parameter int STEP = 1,
    parameter int W    = $clog2(MAX + 1)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic clr,
    output logic      ovf
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= W'(MIN);
        end else if (clr) begin
            r_count <= W'(MIN);
        end else if (en) begin
            if (r_count >= W'(MAX)) r_count <= W'(MIN);
            else                    r_count <= r_count + W'(STEP);
        end
    end

    assign ovf = en && (r_count == W'(MAX));

endmodule
`default_nettype wire

// File: rtl/rgb_fader.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fader
// Brief    : Steps a registered RGB colour through a programmable table,
//            fading one LSB per tick and holding each entry for hold+1 ticks.
// Revision : 1.0
// ============================================================================
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int NBPC  = 8,
    parameter int NCOL  = 4,
    parameter int PRESC = 1000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    rgb_fader_if.slave  bus
);

    localparam int IW = $clog2(NCOL);
    localparam int CW = 3 * NBPC;

    logic [CW-1:0]  r_table [NCOL];
    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic [7:0]     r_hold_cnt, w_hold_cnt_nxt;
    logic [CW-1:0]  r_color, w_color_nxt;
    logic           r_busy;
    logic           r_step_done, w_step_done_nxt;
    logic           w_tick, w_presc_clr, w_presc_en;
    logic [CW-1:0]  w_target;

    function automatic logic [NBPC-1:0] step_toward(input logic [NBPC-1:0] cur,
                                                    input logic [NBPC-1:0] tgt);
        if (cur < tgt)      return cur + 1'b1;
        else if (cur > tgt) return cur - 1'b1;
        else                return cur;
    endfunction

    assign w_target   = r_table[r_idx];
    assign w_presc_en = bus.en && (r_state != ST_IDLE);

    rgb_fader_counter #(
        .MIN  (0),
        .MAX  (PRESC - 1),
        .STEP (1)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .en  (w_presc_en),
        .clr (w_presc_clr),
        .ovf (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCOL; i++) r_table[i] <= '0;
        end else if (bus.wr_en) begin
            r_table[bus.wr_idx] <= bus.wr_data;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_color_nxt     = r_color;
        w_step_done_nxt = 1'b0;
        w_presc_clr     = 1'b0;

        // stop overrides everything, including a frozen (en low) sequencer
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
            w_color_nxt = '0;
        end else if (bus.en) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_FADE;
                        w_idx_nxt   = '0;
                        w_presc_clr = 1'b1;
                    end
                end
                ST_FADE: begin
                    if (w_tick) begin
                        if (r_color == w_target) begin
                            w_state_nxt    = ST_HOLD;
                            w_hold_cnt_nxt = '0;
                        end else begin
                            for (int ch = 0; ch < NUM_CH; ch++) begin
                                w_color_nxt[ch_lsb(ch, NBPC) +: NBPC] =
                                    step_toward(r_color[ch_lsb(ch, NBPC) +: NBPC],
                                                w_target[ch_lsb(ch, NBPC) +: NBPC]);
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (r_hold_cnt == bus.hold) begin
                            w_step_done_nxt = 1'b1;
                            if ((r_idx == IW'(NCOL - 1)) && !bus.loop) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_FADE;
                                w_idx_nxt   = r_idx + 1'b1;
                            end
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_hold_cnt  <= '0;
            r_color     <= '0;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_color     <= w_color_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_step_done <= w_step_done_nxt;
        end
    end

    assign bus.color     = r_color;
    assign bus.busy      = r_busy;
    assign bus.idx       = r_idx;
    assign bus.step_done = r_step_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_fader
// Brief    : Self-checking bench; expected colours come from distance arithmetic.
// Revision : 1.0
// ============================================================================
module tb_rgb_fader;

    localparam int NBPC  = 8;
    localparam int NCOL  = 4;
    localparam int PRESC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rgb_fader_if #(.NBPC(NBPC), .NCOL(NCOL)) bus ();

    rgb_fader #(.NBPC(NBPC), .NCOL(NCOL), .PRESC(PRESC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          since  = 0;
    logic [23:0] model_tbl [NCOL];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to just after the next fade tick edge.
    task automatic tick();
        cyc(PRESC - since);
        since = 0;
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int max_dist(input logic [23:0] a, input logic [23:0] b);
        int m = 0;
        for (int c = 0; c < 3; c++) begin
            int d = absdiff(int'(a[8*c +: 8]), int'(b[8*c +: 8]));
            if (d > m) m = d;
        end
        return m;
    endfunction

    // Colour k ticks into a fade: each channel has moved min(k, distance) toward target.
    function automatic logic [23:0] fade_at(input logic [23:0] from, input logic [23:0] to, input int k);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            int f = int'(from[8*c +: 8]);
            int t = int'(to[8*c +: 8]);
            int m = (absdiff(f, t) < k) ? absdiff(f, t) : k;
            r[8*c +: 8] = 8'((t >= f) ? f + m : f - m);
        end
        return r;
    endfunction

    task automatic write_entry(input int i, input logic [23:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 2'(i);
        bus.wr_data = v;
        cyc(1);
        bus.wr_en   = 1'b0;
        model_tbl[i] = v;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        since = 0;
        checks++;
        if (bus.busy !== 1'b1 || bus.idx !== 2'd0) begin
            errors++;
            $display("FAIL start: busy=%b idx=%0d expected busy=1 idx=0", bus.busy, bus.idx);
        end
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        checks++;
        if (bus.color !== 24'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop: color=%h busy=%b expected color=000000 busy=0", bus.color, bus.busy);
        end
    endtask

    // Walk n entries from the current table, starting from colour 0 at idx 0.
    task automatic check_sequence(input int n_steps);
        logic [23:0] cur = 24'h0;
        for (int s = 0; s < n_steps; s++) begin
            int          i    = s % NCOL;
            logic [23:0] tgt  = model_tbl[i];
            int          d    = max_dist(cur, tgt);
            logic        last = (i == NCOL - 1) && !bus.loop;
            logic [1:0]  eidx = last ? 2'(NCOL - 1) : 2'((i + 1) % NCOL);
            for (int k = 1; k <= d; k++) begin
                tick();
                checks++;
                if (bus.color !== fade_at(cur, tgt, k)) begin
                    errors++;
                    $display("FAIL fade_color: entry %0d tick %0d got %h expected %h", i, k, bus.color, fade_at(cur, tgt, k));
                end
            end
            tick();
            checks++;
            if (bus.color !== tgt || bus.step_done !== 1'b0) begin
                errors++;
                $display("FAIL hold_entry: entry %0d color=%h step_done=%b expected %h 0", i, bus.color, bus.step_done, tgt);
            end
            for (int h = 0; h < int'(bus.hold); h++) begin
                tick();
                checks++;
                if (bus.step_done !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_early: entry %0d hold tick %0d step_done=%b expected 0", i, h, bus.step_done);
                end
            end
            tick();
            checks++;
            if (bus.step_done !== 1'b1 || bus.idx !== eidx || bus.busy !== !last) begin
                errors++;
                $display("FAIL step_done: entry %0d step_done=%b idx=%0d busy=%b expected 1 %0d %b",
                         i, bus.step_done, bus.idx, bus.busy, eidx, !last);
            end
            cyc(1);
            since = 1;
            checks++;
            if (bus.step_done !== 1'b0) begin
                errors++;
                $display("FAIL step_pulse_width: step_done=%b expected 0", bus.step_done);
            end
            cur = tgt;
            if (last) break;
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.hold = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < NCOL; i++) model_tbl[i] = 24'h0;
        rst = 1'b0;
        cyc(2);
        checks++;
        if (bus.color !== 24'h0 || bus.busy !== 1'b0 || bus.idx !== 2'd0 || bus.step_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: color=%h busy=%b idx=%0d step_done=%b expected 000000 0 0 0",
                     bus.color, bus.busy, bus.idx, bus.step_done);
        end
        rst = 1'b1;
        bus.en = 1'b1;
        cyc(1);
    endtask

    task automatic test_single_entry();
        write_entry(0, 24'h030000);
        bus.hold = 8'd2;
        bus.loop = 1'b0;
        do_start();
        check_sequence(1);
        do_stop();
    endtask

    task automatic test_opposite();
        write_entry(0, 24'h050505);
        write_entry(1, 24'h020708);
        bus.hold = 8'd0;
        do_start();
        check_sequence(2);
        do_stop();
    endtask

    task automatic test_all_zero(input logic lp);
        for (int i = 0; i < NCOL; i++) write_entry(i, 24'h0);
        bus.hold = 8'd0;
        bus.loop = lp;
        do_start();
        check_sequence(lp ? NCOL + 1 : NCOL);
        do_stop();
        bus.loop = 1'b0;
    endtask

    task automatic test_random();
        repeat (4) begin
            for (int i = 0; i < NCOL; i++)
                write_entry(i, {8'($urandom_range(0, 10)), 8'($urandom_range(0, 10)), 8'($urandom_range(0, 10))});
            bus.hold = 8'($urandom_range(0, 3));
            bus.loop = 1'b0;
            do_start();
            check_sequence(NCOL);
            do_stop();
        end
    endtask

    task automatic test_stop_start();
        write_entry(0, 24'h0A0A0A);
        bus.hold = 8'd0;
        do_start();
        tick();
        tick();
        checks++;
        if (bus.color !== 24'h020202) begin
            errors++;
            $display("FAIL pre_stop_color: got %h expected 020202", bus.color);
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (bus.color !== 24'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_wins: color=%h busy=%b expected 000000 0", bus.color, bus.busy);
        end
        cyc(3);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stay_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_en_freeze();
        do_start();
        tick();
        tick();
        bus.en = 1'b0;
        cyc(5);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(14);
        checks++;
        if (bus.color !== 24'h020202 || bus.idx !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL freeze: color=%h idx=%0d busy=%b expected 020202 0 1", bus.color, bus.idx, bus.busy);
        end
        bus.en = 1'b1;
        since = 0;
        tick();
        checks++;
        if (bus.color !== 24'h030303) begin
            errors++;
            $display("FAIL resume: got %h expected 030303", bus.color);
        end
        bus.en = 1'b0;
        do_stop();
        bus.en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_opposite();
        test_all_zero(1'b0);
        test_all_zero(1'b1);
        test_random();
        test_stop_start();
        test_en_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_fader.md
RGB_FADER -- requirements
Module: rgb_fader

Interface
REQ-001 SHALL have parameter NBPC, default 8, bits per colour channel.
REQ-002 SHALL have parameter NCOL, default 4, colour table entries (power of 2, >=2).
REQ-003 SHALL have parameter PRESC, default 1000, clock cycles per fade tick (>=2).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  run enable; low freezes sequencing.
REQ-007 wr_en  in  1  colour table write strobe.
REQ-008 wr_idx  in  $clog2(NCOL)  table write address.
REQ-009 wr_data  in  3*NBPC  table write data, {R,G,B} MSB first.
REQ-010 hold  in  8  hold time per entry, in ticks.
REQ-011 loop  in  1  wrap to entry 0 after last entry.
REQ-012 start  in  1  one-cycle start pulse.
REQ-013 stop  in  1  one-cycle stop pulse.
REQ-014 color  out  3*NBPC  registered colour, {R,G,B}, drives PWM stage input.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 idx  out  $clog2(NCOL)  current target entry.
REQ-017 step_done  out  1  one-cycle pulse when an entry's hold completes.

Function
REQ-018 Table SHALL be NCOL registers of 3*NBPC bits; wr_en writes wr_data to wr_idx in any state, even with en low; new value is visible as target from the next cycle.
REQ-019 FSM states SHALL be IDLE, FADE, HOLD.
REQ-020 Tick: one-cycle strobe every PRESC cycles, counted only with en high and state != IDLE; prescaler cleared on IDLE->FADE.
REQ-021 IDLE: start with en high and stop low -> FADE next cycle, idx<=0; color unchanged.
REQ-022 FADE, on tick: if color equals table[idx] -> HOLD, hold_cnt<=0; else each channel independently +1 if below target, -1 if above, unchanged if equal.
REQ-023 Channel arithmetic SHALL be unsigned NBPC-bit, never wrap (steps only toward target).
REQ-024 HOLD, on tick: if hold_cnt == hold -> step_done pulse, advance; else hold_cnt+1 (hold=N gives N+1 ticks in HOLD).
REQ-025 Advance: if idx == NCOL-1 and loop low -> IDLE, idx held at NCOL-1; else idx <= idx+1 modulo NCOL, -> FADE.
REQ-026 stop SHALL force IDLE and color<=0 next cycle from any state, regardless of en; stop wins over simultaneous start.
REQ-027 start while busy SHALL be ignored.
REQ-028 en low: state, idx, hold_cnt, prescaler, color all held; start ignored.
REQ-029 hold or table changed mid-step: new value used at the next evaluating tick.
REQ-030 All outputs SHALL be registered; step_done high exactly one cycle per advance.

Reset
REQ-031 rst low at clk edge: state IDLE, color 0, idx 0, busy 0, step_done 0, hold_cnt 0, prescaler 0, all table entries 0.
REQ-032 Reset mid-fade SHALL abandon the sequence with no step_done pulse.

Structure
REQ-033 Shared package SHALL hold FSM state encoding and {R,G,B} channel-slice constants shared with the PWM stage.
REQ-034 Prescaler SHALL be one instance of existing sub-module counter (min 0, max PRESC-1, step 1), overflow used as tick, clr driven on IDLE->FADE.

Verification (bench uses PRESC=4, NCOL=4, NBPC=8)
REQ-035 Reset: rst low 2 cycles -> color=0x000000, busy=0, idx=0, step_done=0.
REQ-036 table[0]=0x030000, hold=2, loop=0, start -> R=1,2,3 at ticks 1-3, HOLD at tick 4, step_done at tick 7, idx=1.
REQ-037 color=0x050505 reached, next entry 0x020708 -> after 3 ticks color=0x020708, channels moved in opposite directions.
REQ-038 All entries 0, hold=0, loop=0, start -> 4 step_done pulses 2 ticks apart, busy falls after 4th, idx=3.
REQ-039 Same with loop=1 -> idx 3->0 after 4th step_done, busy stays 1.
REQ-040 start and stop same cycle mid-FADE -> IDLE, color=0 next cycle; en low 20 cycles mid-FADE -> color and idx unchanged.
